// File: rtl/jk_mode_pkg.sv
// Shared mode encodings for the JK mode register, so control-unit code
// decodes iMode with exactly the same constants as the datapath.
package jk_mode_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_RING = 2'b11
    } mode_e;

endpackage

// File: rtl/jk_bit_cell.sv
// One-bit JK storage cell: updates on the falling clock edge and clears
// asynchronously while iReset is high.
module jk_bit_cell (
    input  logic iClk,
    input  logic iReset,
    input  logic iJ,
    input  logic iK,
    output logic oQ
);

    logic bit_q;

    always_ff @(negedge iClk or posedge iReset) begin
        if (iReset) begin
            bit_q <= 1'b0;
        end else begin
            case ({iJ, iK})
                2'b01:   bit_q <= 1'b0;
                2'b10:   bit_q <= 1'b1;
                2'b11:   bit_q <= ~bit_q;
                default: bit_q <= bit_q;
            endcase
        end
    end

    assign oQ = bit_q;

endmodule

// File: rtl/jk_mode_register.sv
// Multi-mode WIDTH-bit register (JK / mod-N up / mod-N down / one-hot ring)
// built from jk_bit_cell instances. Define ONEHOT_GUARD_EN to force ring mode
// back to a single hot bit whenever the state is not exactly one-hot.
module jk_mode_register
    import jk_mode_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iEn,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iD,
    input  logic [1:0]       iMode,
    input  logic [WIDTH-1:0] iJ,
    input  logic [WIDTH-1:0] iK,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oQb,
    output logic             oTc
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] cellJ;
    logic [WIDTH-1:0] cellK;
    logic             term;
    logic             ringRestart;

`ifdef ONEHOT_GUARD_EN
    assign ringRestart = !$onehot(state_q);
`else
    assign ringRestart = (state_q == '0);
`endif

    // Next state is decided as a whole word; out-of-range counts recover in
    // one edge (up wraps to 0, down jumps to MODULUS-1).
    always_comb begin
        next_d = state_q;
        if (iLoad) begin
            next_d = iD;
        end else if (iEn) begin
            case (mode_e'(iMode))
                MODE_JK:   next_d = (state_q & ~iK) | (~state_q & iJ);
                MODE_UP:   next_d = (state_q >= LAST) ? '0 : state_q + ONE;
                MODE_DN:   next_d = ((state_q == '0) || (state_q > LAST)) ? LAST
                                                                          : state_q - ONE;
                MODE_RING: next_d = ringRestart ? ONE
                                                : {state_q[WIDTH-2:0], state_q[WIDTH-1]};
                default:   next_d = state_q;
            endcase
        end
    end

    always_comb begin
        term = 1'b0;
        case (mode_e'(iMode))
            MODE_UP:   term = (state_q == LAST);
            MODE_DN:   term = (state_q == '0);
            MODE_RING: term = state_q[WIDTH-1];
            default:   term = 1'b0;
        endcase
    end

    // Each cell gets set/clear requests only where its bit must change.
    assign cellJ = next_d & ~state_q;
    assign cellK = ~next_d & state_q;

    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        jk_bit_cell uCell (
            .iClk   (iClk),
            .iReset (iReset),
            .iJ     (cellJ[i]),
            .iK     (cellK[i]),
            .oQ     (state_q[i])
        );
    end

    assign oQ  = state_q;
    assign oQb = ~state_q;
    assign oTc = iEn & ~iLoad & term;

endmodule

// File: tb/tb_jk_mode_register.sv
// Directed self-checking bench for jk_mode_register at WIDTH=4, MODULUS=10.
// Honors ONEHOT_GUARD_EN for the multi-hot ring expectation.
module tb_jk_mode_register;

    logic       iClk;
    logic       iReset;
    logic       iEn;
    logic       iLoad;
    logic [3:0] iD;
    logic [1:0] iMode;
    logic [3:0] iJ;
    logic [3:0] iK;
    logic [3:0] oQ;
    logic [3:0] oQb;
    logic       oTc;

    int nChecks = 0;
    int nFails  = 0;

    jk_mode_register #(.WIDTH(4), .MODULUS(10)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .iEn    (iEn),
        .iLoad  (iLoad),
        .iD     (iD),
        .iMode  (iMode),
        .iJ     (iJ),
        .iK     (iK),
        .oQ     (oQ),
        .oQb    (oQb),
        .oTc    (oTc)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance past one falling edge and settle away from it.
    task automatic step();
        @(negedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iReset = 1'b0;
        #2 iReset = 1'b1;
        #1;
        nChecks++;
        if (oQ !== 4'h0) begin nFails++; $display("[TB] FAIL reset_q: got %h expected 0", oQ); end
        nChecks++;
        if (oQb !== 4'hF) begin nFails++; $display("[TB] FAIL reset_qb: got %h expected F", oQb); end
        iMode = 2'b01; iEn = 1'b1;
        step(); step();
        nChecks++;
        if (oQ !== 4'h0) begin nFails++; $display("[TB] FAIL reset_held: got %h expected 0", oQ); end
        iReset = 1'b0;
    endtask

    task automatic test_up();
        logic [3:0] exp;
        iMode = 2'b01; iEn = 1'b1; iLoad = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = (i == 10) ? 4'd0 : 4'(i);
            nChecks++;
            if (oQ !== exp) begin nFails++; $display("[TB] FAIL up_count[%0d]: got %0d expected %0d", i, oQ, exp); end
            nChecks++;
            if (oTc !== (exp == 4'd9)) begin nFails++; $display("[TB] FAIL up_tc[%0d]: got %b expected %b", i, oTc, (exp == 4'd9)); end
        end
        iLoad = 1'b1; iD = 4'd12;
        step();
        nChecks++;
        if (oQ !== 4'd12) begin nFails++; $display("[TB] FAIL up_load12: got %0d expected 12", oQ); end
        iLoad = 1'b0;
        step();
        nChecks++;
        if (oQ !== 4'd0) begin nFails++; $display("[TB] FAIL up_recover: got %0d expected 0", oQ); end
    endtask

    task automatic test_reset_mid();
        iMode = 2'b01; iEn = 1'b1; iLoad = 1'b0;
        for (int i = 0; i < 6; i++) step();
        nChecks++;
        if (oQ !== 4'd6) begin nFails++; $display("[TB] FAIL mid_count6: got %0d expected 6", oQ); end
        #2 iReset = 1'b1;
        #1;
        nChecks++;
        if (oQ !== 4'd0) begin nFails++; $display("[TB] FAIL mid_reset_q: got %0d expected 0", oQ); end
        nChecks++;
        if (oQb !== 4'hF) begin nFails++; $display("[TB] FAIL mid_reset_qb: got %h expected F", oQb); end
        step(); step();
        nChecks++;
        if (oQ !== 4'd0) begin nFails++; $display("[TB] FAIL mid_reset_held: got %0d expected 0", oQ); end
        #2 iReset = 1'b0;
        step();
        nChecks++;
        if (oQ !== 4'd1) begin nFails++; $display("[TB] FAIL mid_first_edge: got %0d expected 1", oQ); end
    endtask

    task automatic test_down();
        logic [3:0] seq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
        iMode = 2'b10; iEn = 1'b1; iLoad = 1'b1; iD = 4'd2;
        step();
        iLoad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            nChecks++;
            if (oQ !== seq[i]) begin nFails++; $display("[TB] FAIL down_count[%0d]: got %0d expected %0d", i, oQ, seq[i]); end
            nChecks++;
            if (oTc !== (seq[i] == 4'd0)) begin nFails++; $display("[TB] FAIL down_tc[%0d]: got %b expected %b", i, oTc, (seq[i] == 4'd0)); end
        end
        iLoad = 1'b1; iD = 4'd0;
        step();
        iLoad = 1'b0; iEn = 1'b0;
        #1;
        nChecks++;
        if (oTc !== 1'b0) begin nFails++; $display("[TB] FAIL down_tc_disabled: got %b expected 0", oTc); end
        step();
        nChecks++;
        if (oQ !== 4'd0) begin nFails++; $display("[TB] FAIL down_hold: got %0d expected 0", oQ); end
        iEn = 1'b1;
        #1;
        nChecks++;
        if (oTc !== 1'b1) begin nFails++; $display("[TB] FAIL down_tc_enabled: got %b expected 1", oTc); end
        iLoad = 1'b1; iD = 4'd14;
        step();
        iLoad = 1'b0;
        step();
        nChecks++;
        if (oQ !== 4'd9) begin nFails++; $display("[TB] FAIL down_recover: got %0d expected 9", oQ); end
    endtask

    task automatic test_jk();
        iMode = 2'b00; iEn = 1'b1; iLoad = 1'b1; iD = 4'b1010;
        step();
        iLoad = 1'b0; iJ = 4'b0101; iK = 4'b1001;
        step();
        nChecks++;
        if (oQ !== 4'b0111) begin nFails++; $display("[TB] FAIL jk_update: got %b expected 0111", oQ); end
        nChecks++;
        if (oTc !== 1'b0) begin nFails++; $display("[TB] FAIL jk_tc: got %b expected 0", oTc); end
        iEn = 1'b0; iJ = 4'b1111; iK = 4'b1111;
        step();
        nChecks++;
        if (oQ !== 4'b0111) begin nFails++; $display("[TB] FAIL jk_hold: got %b expected 0111", oQ); end
        iJ = 4'b0000; iK = 4'b0000;
    endtask

    task automatic test_ring();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] multiExp;
        #2 iReset = 1'b1;
        #2 iReset = 1'b0;
        iMode = 2'b11; iEn = 1'b1; iLoad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            nChecks++;
            if (oQ !== seq[i]) begin nFails++; $display("[TB] FAIL ring_seq[%0d]: got %b expected %b", i, oQ, seq[i]); end
            nChecks++;
            if (oTc !== seq[i][3]) begin nFails++; $display("[TB] FAIL ring_tc[%0d]: got %b expected %b", i, oTc, seq[i][3]); end
        end
        iLoad = 1'b1; iD = 4'b0110;
        step();
        iLoad = 1'b0;
        step();
`ifdef ONEHOT_GUARD_EN
        multiExp = 4'b0001;
`else
        multiExp = 4'b1100;
`endif
        nChecks++;
        if (oQ !== multiExp) begin nFails++; $display("[TB] FAIL ring_multihot: got %b expected %b", oQ, multiExp); end
    endtask

    task automatic test_priority();
        iMode = 2'b01; iEn = 1'b0; iLoad = 1'b1; iD = 4'd5;
        step();
        nChecks++;
        if (oQ !== 4'd5) begin nFails++; $display("[TB] FAIL prio_load: got %0d expected 5", oQ); end
        nChecks++;
        if (oTc !== 1'b0) begin nFails++; $display("[TB] FAIL prio_tc: got %b expected 0", oTc); end
        iReset = 1'b1;
        #1;
        nChecks++;
        if (oQ !== 4'd0) begin nFails++; $display("[TB] FAIL prio_reset_async: got %0d expected 0", oQ); end
        step();
        nChecks++;
        if (oQ !== 4'd0) begin nFails++; $display("[TB] FAIL prio_reset_over_load: got %0d expected 0", oQ); end
        iReset = 1'b0; iLoad = 1'b0;
    endtask

    task automatic test_mode_change();
        iMode = 2'b01; iEn = 1'b1; iLoad = 1'b1; iD = 4'd5;
        step();
        iLoad = 1'b0; iMode = 2'b10;
        step();
        nChecks++;
        if (oQ !== 4'd4) begin nFails++; $display("[TB] FAIL mode_up_to_down: got %0d expected 4", oQ); end
        iMode = 2'b01;
        step();
        nChecks++;
        if (oQ !== 4'd5) begin nFails++; $display("[TB] FAIL mode_down_to_up: got %0d expected 5", oQ); end
        nChecks++;
        if (oQb !== 4'hA) begin nFails++; $display("[TB] FAIL mode_qb: got %h expected A", oQb); end
    endtask

    initial begin
        iReset = 1'b0; iEn = 1'b0; iLoad = 1'b0; iD = '0;
        iMode = 2'b00; iJ = '0; iK = '0;
        test_reset();
        test_up();
        test_reset_mid();
        test_down();
        test_jk();
        test_ring();
        test_priority();
        test_mode_change();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
